relay_credit_source: RTL and testbench

Transmitter end of a credit-based inter-slot stream link. Reads words from a local first-word fall-through (FWFT) FIFO and launches them through LEVEL register stages toward a remote receiver FIFO of depth CREDITS. Sends only while it holds credit; the receiver returns one credit pulse per word it pops, and these pulses travel back through RET_LEVEL register stages. Because every forward and return signal is registered, the link floorplans across slots without an almost-full grace margin.

---
 rtl/relay_credit_source.sv | 110 +++++++++++
 tb/tb_relay_credit_source.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/relay_credit_source.sv
`timescale 1ns/1ps
// Credit-based stream link transmitter: FWFT pop, registered forward and credit-return pipes.
// Define RELAY_CREDIT_SOURCE_CHECK_EN to build the sticky credit-overflow flag (err).
module relay_credit_source #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CREDITS      = 8,
  parameter int unsigned LEVEL        = 2,
  parameter int unsigned RET_LEVEL    = 2,
  parameter int unsigned CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_empty_n,
  output logic                    if_read,
  input  logic [DATA_WIDTH-1:0]   if_dout,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_avail,
  output logic [CREDIT_WIDTH-1:0] in_flight,
  output logic                    err
);
  localparam logic [CREDIT_WIDTH-1:0] CredMax = CREDIT_WIDTH'(CREDITS);

  logic [CREDIT_WIDTH-1:0] r_cred;
  logic                    w_send;
  logic                    w_ret;
  logic                    w_full;
  logic [LEVEL-1:0]        r_vld;
  logic [DATA_WIDTH-1:0]   r_data [LEVEL];

  // A credit returning in a cred==0 cycle is only usable from the next cycle.
  assign w_send  = if_empty_n & (r_cred != '0) & ~reset;
  assign w_full  = (r_cred == CredMax);
  assign if_read = w_send;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_send;
      for (int k = 1; k < LEVEL; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  // Payload shifts unconditionally; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    r_data[0] <= if_dout;
    for (int k = 1; k < LEVEL; k++) r_data[k] <= r_data[k-1];
  end

  generate
    if (RET_LEVEL == 0) begin : g_ret_direct
      assign w_ret = credit_in;
    end else begin : g_ret_pipe
      logic [RET_LEVEL-1:0] r_ret;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_ret <= '0;
        end else begin
          r_ret[0] <= credit_in;
          for (int k = 1; k < RET_LEVEL; k++) r_ret[k] <= r_ret[k-1];
        end
      end
      assign w_ret = r_ret[RET_LEVEL-1];
    end
  endgenerate

  // Saturate at CREDITS: a surplus return is dropped rather than wrapping the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cred <= CredMax;
    end else if (w_send && !w_ret) begin
      r_cred <= r_cred - CREDIT_WIDTH'(1);
    end else if (w_ret && !w_send && !w_full) begin
      r_cred <= r_cred + CREDIT_WIDTH'(1);
    end
  end

  assign out_valid    = r_vld[LEVEL-1];
  assign out_data     = r_data[LEVEL-1];
  assign credit_avail = r_cred;
  assign in_flight    = CredMax - r_cred;

`ifdef RELAY_CREDIT_SOURCE_CHECK_EN
  logic w_overflow;
  logic r_err;

  assign w_overflow = w_ret & ~w_send & w_full & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_overflow) begin
      r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (w_overflow) $error("relay_credit_source: credit return with counter already full");
  end
`endif

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_relay_credit_source.sv
`timescale 1ns/1ps
// Directed bench: a CREDITS=4 instance for start-up, credit return, overflow and reset
// corners, plus a CREDITS=8 instance with credit_in looped from out_valid for throughput.
module tb_relay_credit_source;
  localparam int unsigned DW = 8;

`ifdef RELAY_CREDIT_SOURCE_CHECK_EN
  localparam logic ErrOvf = 1'b1;
`else
  localparam logic ErrOvf = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, empty_n_a, read_a, valid_a, credit_a, err_a;
  logic [DW-1:0] dout_a, data_a;
  logic [2:0]    avail_a, flight_a;

  logic          reset_b, read_b, valid_b, err_b;
  logic [DW-1:0] dout_b, data_b;
  logic [3:0]    avail_b, flight_b;

  relay_credit_source #(
    .DATA_WIDTH(DW), .CREDITS(4), .LEVEL(2), .RET_LEVEL(2)
  ) u_dut_a (
    .clk(clk), .reset(reset_a), .if_empty_n(empty_n_a), .if_read(read_a),
    .if_dout(dout_a), .out_valid(valid_a), .out_data(data_a), .credit_in(credit_a),
    .credit_avail(avail_a), .in_flight(flight_a), .err(err_a)
  );

  relay_credit_source #(
    .DATA_WIDTH(DW), .CREDITS(8), .LEVEL(2), .RET_LEVEL(2)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .if_empty_n(1'b1), .if_read(read_b),
    .if_dout(dout_b), .out_valid(valid_b), .out_data(data_b), .credit_in(valid_b),
    .credit_avail(avail_b), .in_flight(flight_b), .err(err_b)
  );

  typedef struct {
    logic          en;
    logic          cr;
    logic          rd;
    logic          vld;
    logic          chk_d;
    logic [DW-1:0] d;
    logic [2:0]    avail;
  } vec_t;

  vec_t          tbl [15];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          rd_prev_a = 1'b0;
  logic          rd_prev_b = 1'b0;
  logic [DW-1:0] q_b [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: model the FIFOs popping on last cycle's if_read, drive inputs, let comb settle.
  task automatic step(input logic rst_a, input logic en_a, input logic cr_a, input logic rst_b);
    @(negedge clk);
    if (rd_prev_a) dout_a = dout_a + DW'(1);
    if (rd_prev_b) begin
      q_b.push_back(dout_b);
      dout_b = dout_b + DW'(1);
    end
    reset_a   = rst_a;
    empty_n_a = en_a;
    credit_a  = cr_a;
    reset_b   = rst_b;
    #1;
    rd_prev_a = read_a;
    rd_prev_b = read_b;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] avail, input logic vld);
    chk({tag, "_avail"}, 32'(avail_a), 32'(avail));
    chk({tag, "_flight"}, 32'(flight_a), 32'(3'd4 - avail));
    chk({tag, "_valid"}, 32'(valid_a), 32'(vld));
  endtask

  task automatic sb_b(input string tag);
    if (valid_b) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_extra: got word %0h, expected no word", tag, data_b);
      end else begin
        chk({tag, "_data"}, 32'(data_b), 32'(q_b.pop_front()));
      end
    end
  endtask

  initial begin
    // {en, cr, rd, vld, chk_d, data, avail} per cycle after reset release
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 3'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 3'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h14, 3'd0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    dout_a = 8'h10; dout_b = 8'h80;
    reset_a = 1'b1; reset_b = 1'b1; empty_n_a = 1'b0; credit_a = 1'b0;

    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_read", 32'(read_a), 0);
    chk_a("rst", 3'd4, 1'b0);
    chk("rst_err", 32'(err_a), 0);

    // Start-up burst, exhaustion, single credit return
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].en, tbl[i].cr, 1'b1);
      chk($sformatf("tbl%0d_read", i), 32'(read_a), 32'(tbl[i].rd));
      chk_a($sformatf("tbl%0d", i), tbl[i].avail, tbl[i].vld);
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), 32'(data_a), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_err", i), 32'(err_a), 0);
    end

    // Build cred up to 2, then send and return in the same cycle
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ret1_avail", 32'(avail_a), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ret2_avail", 32'(avail_a), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("simul_read", 32'(read_a), 1);
    chk("simul_pre_avail", 32'(avail_a), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("simul_post_avail", 32'(avail_a), 2);

    // Refill to CREDITS, then one surplus return arrives with nothing to send
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("simul_word_valid", 32'(valid_a), 1);
    chk("simul_word_data", 32'(data_a), 32'h15);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill3_avail", 32'(avail_a), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill4_avail", 32'(avail_a), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_a("ovf", 3'd4, 1'b0);
    chk("ovf_err", 32'(err_a), 32'(ErrOvf));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky_avail", 32'(avail_a), 4);
    chk("ovf_sticky_err", 32'(err_a), 32'(ErrOvf));

    // Reset with 3 words launched and 2 credits in the return pipe
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_read", 32'(read_a), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_a("post_rst", 3'd4, 1'b0);
    chk("post_rst_err", 32'(err_a), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_a($sformatf("stale%0d", i), 3'd4, 1'b0);
    end

    // Sustained throughput with looped-back credits
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_first_read", 32'(read_b), 1);
    chk("b_first_avail", 32'(avail_b), 8);
    chk("b_first_valid", 32'(valid_b), 0);
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      sb_b("b_warm");
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("b_read", 32'(read_b), 1);
      chk("b_valid", 32'(valid_b), 1);
      chk("b_avail", 32'(avail_b), 4);
      chk("b_flight", 32'(flight_b), 4);
      chk("b_err", 32'(err_b), 0);
      sb_b("b_run");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
